// File: rtl/uart_buffered_tx_if.sv
// Byte-write and serial-status bundle for the buffered UART transmitter.
// The master side queues bytes and sets the baud period; the slave side is the transmitter.
interface uart_buffered_tx_if #(
    parameter int CLOCK_SCALE_BITS = 16,
    parameter int FIFO_DEPTH_LOG2  = 4
);
    logic [CLOCK_SCALE_BITS-1:0] cyclesPerBit;
    logic                        blockTransmission;
    logic                        writeEnable;
    logic [7:0]                  writeData;
    logic                        full;
    logic                        empty;
    logic [FIFO_DEPTH_LOG2:0]    count;
    logic                        overflow;
    logic                        busy;
    logic                        tx;

    modport master (
        output cyclesPerBit, blockTransmission, writeEnable, writeData,
        input  full, empty, count, overflow, busy, tx
    );

    modport slave (
        input  cyclesPerBit, blockTransmission, writeEnable, writeData,
        output full, empty, count, overflow, busy, tx
    );
endinterface

// File: rtl/uart_buffered_tx.sv
// 8N1 UART transmitter fed by a byte FIFO; frames run back-to-back while bytes remain
// and blockTransmission is low. All outputs come straight from registers.
module uart_buffered_tx #(
    parameter int CLOCK_SCALE_BITS = 16,
    parameter int FIFO_DEPTH_LOG2  = 4
) (
    input logic                clk,
    input logic                rst,
    uart_buffered_tx_if.slave  bus
);
    localparam int AW = FIFO_DEPTH_LOG2;
    localparam int CW = CLOCK_SCALE_BITS;
    localparam int DEPTH = 1 << AW;
    localparam logic [AW:0]    DEPTH_CNT  = {1'b1, {AW{1'b0}}};
    localparam logic [AW:0]    CNT_ONE    = {{AW{1'b0}}, 1'b1};
    localparam logic [AW-1:0]  PTR_ONE    = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0]  PERIOD_ONE = {{(CW-1){1'b0}}, 1'b1};

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    logic [7:0]    mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r, rd_ptr_r;
    logic [AW:0]   count_r, count_s;
    logic          full_r, empty_r, overflow_r;

    logic [1:0]    state_r, state_s;
    logic [2:0]    bit_cnt_r, bit_cnt_s;
    logic [CW-1:0] period_cnt_r, period_cnt_s;
    logic [CW-1:0] period_r, period_s;
    logic [7:0]    shift_r, shift_s;
    logic          tx_r, tx_s;
    logic          busy_r;

    logic push_s, drop_s, pop_s, go_s, can_start_s, period_done_s;

    assign push_s        = bus.writeEnable && !full_r;
    assign drop_s        = bus.writeEnable && full_r;
    assign can_start_s   = !empty_r && !bus.blockTransmission;
    assign period_done_s = (period_cnt_r == {CW{1'b0}});

    // FSM next-state: each bit holds for period_r+1 clocks; a new frame loads on go_s
    always_comb begin
        state_s      = state_r;
        bit_cnt_s    = bit_cnt_r;
        period_cnt_s = period_cnt_r;
        period_s     = period_r;
        shift_s      = shift_r;
        tx_s         = tx_r;
        go_s         = 1'b0;
        case (state_r)
            ST_IDLE: begin
                tx_s = 1'b1;
                if (can_start_s) begin
                    go_s = 1'b1;
                end else begin
                    go_s = 1'b0;
                end
            end
            ST_START: begin
                if (period_done_s) begin
                    state_s      = ST_DATA;
                    tx_s         = shift_r[0];
                    shift_s      = {1'b0, shift_r[7:1]};
                    bit_cnt_s    = 3'd0;
                    period_cnt_s = period_r;
                end else begin
                    period_cnt_s = period_cnt_r - PERIOD_ONE;
                end
            end
            ST_DATA: begin
                if (period_done_s) begin
                    period_cnt_s = period_r;
                    if (bit_cnt_r == 3'd7) begin
                        state_s = ST_STOP;
                        tx_s    = 1'b1;
                    end else begin
                        bit_cnt_s = bit_cnt_r + 3'd1;
                        tx_s      = shift_r[0];
                        shift_s   = {1'b0, shift_r[7:1]};
                    end
                end else begin
                    period_cnt_s = period_cnt_r - PERIOD_ONE;
                end
            end
            ST_STOP: begin
                if (period_done_s) begin
                    state_s = ST_IDLE;
                    tx_s    = 1'b1;
                    go_s    = can_start_s;
                end else begin
                    period_cnt_s = period_cnt_r - PERIOD_ONE;
                end
            end
            default: begin
                state_s = ST_IDLE;
                tx_s    = 1'b1;
            end
        endcase
        // Frame start overrides whatever the state branch chose
        if (go_s) begin
            state_s      = ST_START;
            tx_s         = 1'b0;
            shift_s      = mem_r[rd_ptr_r];
            period_s     = bus.cyclesPerBit;
            period_cnt_s = bus.cyclesPerBit;
            bit_cnt_s    = 3'd0;
        end else begin
            period_s = period_r;
        end
    end

    assign pop_s = go_s;

    // FIFO occupancy after this edge's push and pop
    always_comb begin
        if (push_s && !pop_s) begin
            count_s = count_r + CNT_ONE;
        end else if (!push_s && pop_s) begin
            count_s = count_r - CNT_ONE;
        end else begin
            count_s = count_r;
        end
    end

    // State, FIFO pointers and flags; reset aborts any frame and discards the queue
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r      <= ST_IDLE;
            bit_cnt_r    <= 3'd0;
            period_cnt_r <= {CW{1'b0}};
            period_r     <= {CW{1'b0}};
            shift_r      <= 8'h00;
            tx_r         <= 1'b1;
            busy_r       <= 1'b0;
            wr_ptr_r     <= {AW{1'b0}};
            rd_ptr_r     <= {AW{1'b0}};
            count_r      <= {(AW+1){1'b0}};
            full_r       <= 1'b0;
            empty_r      <= 1'b1;
            overflow_r   <= 1'b0;
        end else begin
            state_r      <= state_s;
            bit_cnt_r    <= bit_cnt_s;
            period_cnt_r <= period_cnt_s;
            period_r     <= period_s;
            shift_r      <= shift_s;
            tx_r         <= tx_s;
            busy_r       <= (state_s != ST_IDLE);
            count_r      <= count_s;
            full_r       <= (count_s == DEPTH_CNT);
            empty_r      <= (count_s == {(AW+1){1'b0}});
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            if (drop_s) begin
                overflow_r <= 1'b1;
            end
        end
    end

    // Storage array; no reset needed since contents are only read when counted
    always_ff @(posedge clk) begin
        if (rst && push_s) begin
            mem_r[wr_ptr_r] <= bus.writeData;
        end
    end

    assign bus.tx       = tx_r;
    assign bus.busy     = busy_r;
    assign bus.full     = full_r;
    assign bus.empty    = empty_r;
    assign bus.count    = count_r;
    assign bus.overflow = overflow_r;
endmodule

// File: tb/tb_uart_buffered_tx.sv
// Self-checking bench for uart_buffered_tx: expected line levels come from the 8N1 frame
// definition and a byte queue model; inputs change and outputs are sampled on the falling edge.
module tb_uart_buffered_tx;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;
    logic [7:0] model_q [$];

    uart_buffered_tx_if #(.CLOCK_SCALE_BITS(16), .FIFO_DEPTH_LOG2(4)) bus ();

    uart_buffered_tx #(.CLOCK_SCALE_BITS(16), .FIFO_DEPTH_LOG2(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    function automatic logic frame_bit(input logic [7:0] b, input int k);
        if (k == 0) return 1'b0;
        else if (k >= 9) return 1'b1;
        else return b[k-1];
    endfunction

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b0;
        bus.writeEnable = 1'b0;
        bus.blockTransmission = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic write_byte(input logic [7:0] b);
        bus.writeEnable = 1'b1;
        bus.writeData = b;
        @(negedge clk);
        bus.writeEnable = 1'b0;
    endtask

    // Checks frame positions from..to-1; position 0 is the first clock of the start bit
    task automatic check_frame(input string name, input logic [7:0] b, input int cpb,
                               input int from, input int to);
        for (int i = from; i < to; i++) begin
            logic exp_bit;
            exp_bit = frame_bit(b, i / (cpb + 1));
            checks++;
            if (bus.tx !== exp_bit) begin
                errors++;
                $display("FAIL %s tx pos %0d byte %02h: got %b expected %b", name, i, b, bus.tx, exp_bit);
            end
            checks++;
            if (bus.busy !== 1'b1) begin
                errors++;
                $display("FAIL %s busy pos %0d: got %b expected 1", name, i, bus.busy);
            end
            @(negedge clk);
        end
    endtask

    task automatic check_idle(input string name, input int exp_count);
        checks++;
        if (bus.tx !== 1'b1 || bus.busy !== 1'b0 || bus.count !== 5'(exp_count)) begin
            errors++;
            $display("FAIL %s idle: tx=%b busy=%b count=%0d expected tx=1 busy=0 count=%0d",
                     name, bus.tx, bus.busy, bus.count, exp_count);
        end
    endtask

    task automatic test_reset();
        bus.cyclesPerBit = 16'd3;
        bus.blockTransmission = 1'b0;
        bus.writeEnable = 1'b1;
        bus.writeData = 8'hAA;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.tx !== 1'b1 || bus.busy !== 1'b0 || bus.empty !== 1'b1 || bus.full !== 1'b0 ||
            bus.count !== 5'd0 || bus.overflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_values: tx=%b busy=%b empty=%b full=%b count=%0d ovf=%b expected 1 0 1 0 0 0",
                     bus.tx, bus.busy, bus.empty, bus.full, bus.count, bus.overflow);
        end
        bus.writeEnable = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.empty !== 1'b1) begin
            errors++;
            $display("FAIL reset_write_ignored: empty=%b expected 1", bus.empty);
        end
        check_idle("reset_release", 0);
    endtask

    task automatic test_single();
        apply_reset();
        bus.cyclesPerBit = 16'd3;
        write_byte(8'h55);
        checks++;
        if (bus.count !== 5'd1 || bus.empty !== 1'b0 || bus.tx !== 1'b1) begin
            errors++;
            $display("FAIL single_accept: count=%0d empty=%b tx=%b expected 1 0 1", bus.count, bus.empty, bus.tx);
        end
        @(negedge clk);
        checks++;
        if (bus.count !== 5'd0) begin
            errors++;
            $display("FAIL single_pop: count=%0d expected 0", bus.count);
        end
        check_frame("single_55", 8'h55, 3, 0, 40);
        check_idle("single_end", 0);
    endtask

    task automatic test_back_to_back();
        apply_reset();
        bus.cyclesPerBit = 16'd3;
        bus.writeEnable = 1'b1;
        bus.writeData = 8'hA5;
        @(negedge clk);
        bus.writeData = 8'h3C;
        @(negedge clk);
        bus.writeEnable = 1'b0;
        checks++;
        if (bus.count !== 5'd1) begin
            errors++;
            $display("FAIL b2b_count: count=%0d expected 1", bus.count);
        end
        check_frame("b2b_first", 8'hA5, 3, 0, 40);
        check_frame("b2b_second", 8'h3C, 3, 0, 40);
        check_idle("b2b_end", 0);
    endtask

    task automatic test_overflow();
        apply_reset();
        bus.cyclesPerBit = 16'd1;
        bus.blockTransmission = 1'b1;
        for (int i = 0; i < 16; i++) write_byte(8'(i));
        checks++;
        if (bus.full !== 1'b1 || bus.count !== 5'd16 || bus.overflow !== 1'b0 || bus.tx !== 1'b1) begin
            errors++;
            $display("FAIL ovf_fill: full=%b count=%0d ovf=%b tx=%b expected 1 16 0 1",
                     bus.full, bus.count, bus.overflow, bus.tx);
        end
        // 17th write lands on the same edge as the first pop and must still be dropped
        bus.blockTransmission = 1'b0;
        write_byte(8'h10);
        checks++;
        if (bus.count !== 5'd15 || bus.overflow !== 1'b1 || bus.full !== 1'b0) begin
            errors++;
            $display("FAIL ovf_drop: count=%0d ovf=%b full=%b expected 15 1 0", bus.count, bus.overflow, bus.full);
        end
        for (int i = 0; i < 16; i++) check_frame("ovf_drain", 8'(i), 1, 0, 20);
        check_idle("ovf_end", 0);
        checks++;
        if (bus.overflow !== 1'b1 || bus.empty !== 1'b1) begin
            errors++;
            $display("FAIL ovf_sticky: ovf=%b empty=%b expected 1 1", bus.overflow, bus.empty);
        end
    endtask

    task automatic test_block_midframe();
        apply_reset();
        bus.cyclesPerBit = 16'd1;
        write_byte(8'hC3);
        write_byte(8'h81);
        write_byte(8'h7E);
        bus.blockTransmission = 1'b1;
        checks++;
        if (bus.count !== 5'd2) begin
            errors++;
            $display("FAIL block_count: count=%0d expected 2", bus.count);
        end
        check_frame("block_current", 8'hC3, 1, 1, 20);
        for (int i = 0; i < 10; i++) begin
            check_idle("block_hold", 2);
            @(negedge clk);
        end
        bus.blockTransmission = 1'b0;
        @(negedge clk);
        check_frame("block_after1", 8'h81, 1, 0, 20);
        check_frame("block_after2", 8'h7E, 1, 0, 20);
        check_idle("block_end", 0);
    endtask

    task automatic test_reset_midframe();
        apply_reset();
        bus.cyclesPerBit = 16'd3;
        write_byte(8'h11);
        write_byte(8'h22);
        write_byte(8'h33);
        write_byte(8'h44);
        checks++;
        if (bus.count !== 5'd3) begin
            errors++;
            $display("FAIL rstmid_count: count=%0d expected 3", bus.count);
        end
        repeat (10) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        checks++;
        if (bus.tx !== 1'b1 || bus.busy !== 1'b0 || bus.count !== 5'd0 || bus.empty !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_abort: tx=%b busy=%b count=%0d empty=%b expected 1 0 0 1",
                     bus.tx, bus.busy, bus.count, bus.empty);
        end
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            check_idle("rstmid_quiet", 0);
        end
    endtask

    task automatic test_fast_bit();
        apply_reset();
        bus.cyclesPerBit = 16'd0;
        write_byte(8'hFF);
        @(negedge clk);
        check_frame("cpb0_head", 8'hFF, 0, 0, 5);
        bus.cyclesPerBit = 16'd7;
        check_frame("cpb0_tail", 8'hFF, 0, 5, 10);
        check_idle("cpb0_end", 0);
    endtask

    task automatic test_random();
        for (int it = 0; it < 5; it++) begin
            int cpb;
            int n;
            apply_reset();
            cpb = int'($urandom_range(0, 3));
            n = int'($urandom_range(1, 6));
            bus.cyclesPerBit = 16'(cpb);
            bus.blockTransmission = 1'b1;
            model_q.delete();
            for (int i = 0; i < n; i++) begin
                logic [7:0] b;
                b = 8'($urandom);
                model_q.push_back(b);
                write_byte(b);
            end
            checks++;
            if (bus.count !== 5'(model_q.size()) || bus.tx !== 1'b1) begin
                errors++;
                $display("FAIL rand_fill: count=%0d tx=%b expected %0d 1", bus.count, bus.tx, model_q.size());
            end
            bus.blockTransmission = 1'b0;
            @(negedge clk);
            while (model_q.size() > 0) begin
                logic [7:0] b;
                b = model_q.pop_front();
                check_frame("rand_frame", b, cpb, 0, 10 * (cpb + 1));
            end
            check_idle("rand_end", 0);
        end
    endtask

    initial begin
        bus.cyclesPerBit = 16'd3;
        bus.blockTransmission = 1'b0;
        bus.writeEnable = 1'b0;
        bus.writeData = 8'h00;
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_block_midframe();
        test_reset_midframe();
        test_fast_bit();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_buffered_tx.md
UART_BUFFERED_TX -- requirements
Module: uart_buffered_tx

Interface
REQ-001 SHALL have parameter CLOCK_SCALE_BITS, default 16, width of the bit-period count.
REQ-002 SHALL have parameter FIFO_DEPTH_LOG2, default 4, log2 of the transmit FIFO depth (default depth 16 bytes).
REQ-003 SHALL have port clk  input  1  clock; all logic is on the rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port cyclesPerBit  input  CLOCK_SCALE_BITS  bit period minus one, in clocks.
REQ-006 SHALL have port blockTransmission  input  1  when high, no new frame starts.
REQ-007 SHALL have port writeEnable  input  1  push writeData into the FIFO.
REQ-008 SHALL have port writeData  input  8  byte to enqueue.
REQ-009 SHALL have port full  output  1  FIFO holds DEPTH bytes.
REQ-010 SHALL have port empty  output  1  FIFO holds 0 bytes.
REQ-011 SHALL have port count  output  FIFO_DEPTH_LOG2+1  number of bytes queued, excluding the byte in flight.
REQ-012 SHALL have port overflow  output  1  sticky flag: a write was dropped.
REQ-013 SHALL have port busy  output  1  a frame is in progress (state != IDLE).
REQ-014 SHALL have port tx  output  1  serial line, idle high.

Function
REQ-015 Frame format SHALL be 8N1: one start bit (0), 8 data bits LSB first, one stop bit (1).
REQ-016 Every bit SHALL last exactly cyclesPerBit+1 clocks; cyclesPerBit=0 gives 1 clock per bit, which is legal.
REQ-017 cyclesPerBit SHALL be latched at frame start; changing it mid-frame SHALL NOT affect the current frame.
REQ-018 FSM states SHALL be IDLE, START, DATA and STOP; a bit counter (0..7) and a period down-counter SHALL sequence them.
REQ-019 IDLE -> START SHALL occur on an edge where empty=0 and blockTransmission=0; on that edge the head byte is popped into the shift register and tx is registered low.
REQ-020 START -> DATA after 1 bit period; DATA -> STOP after 8 bit periods; STOP ends after 1 bit period.
REQ-021 At the end of STOP, if empty=0 and blockTransmission=0, the FSM SHALL go directly to START (back-to-back frames, no idle clock); otherwise it SHALL go to IDLE.
REQ-022 blockTransmission SHALL only gate frame start; a frame already in progress SHALL complete.
REQ-023 A write SHALL be accepted when writeEnable=1 and full=0, with full evaluated from registered state; the accepted byte is visible (empty=0, count+1) after that edge.
REQ-024 A write while full=1 SHALL be dropped, even if a pop occurs on the same edge, and SHALL set overflow=1 on that edge.
REQ-025 A simultaneous accepted write and pop SHALL leave count unchanged; the FIFO pointers SHALL wrap modulo DEPTH.
REQ-026 Latency, FIFO empty and FSM idle: a write on edge N SHALL be popped on edge N+1, with tx low from edge N+1; a full frame is 10*(cyclesPerBit+1) clocks.
REQ-027 overflow SHALL clear only on reset.
REQ-028 tx SHALL be driven from a register (glitch-free).

Reset
REQ-029 On a clock edge with rst=0: tx=1, busy=0, state=IDLE, FIFO emptied (empty=1, full=0, count=0), overflow=0, and all counters cleared.
REQ-030 Reset mid-frame SHALL abort the frame: tx=1 from that edge, and queued bytes are discarded.
REQ-031 While rst=0, writes SHALL be ignored.

Verification
REQ-032 cyclesPerBit=3, write 0x55 -> tx low for 4 clocks, then 1,0,1,0,1,0,1,0 for 4 clocks each, then high for 4 clocks; busy high for 40 clocks.
REQ-033 cyclesPerBit=3, write 0xA5 and 0x3C on consecutive cycles -> 80 contiguous clocks of framing with no idle clock between the frames; decoded bytes are 0xA5 then 0x3C.
REQ-034 blockTransmission=1, write 17 bytes 0x00..0x10 -> full=1 and count=16 after 16 writes; the 17th is dropped and overflow=1; tx stays high. Then release blockTransmission -> exactly 16 frames, bytes 0x00..0x0F.
REQ-035 Assert blockTransmission mid-frame, with 2 bytes queued -> the current frame completes, tx stays high and count=2 until release, then the 2 frames follow.
REQ-036 cyclesPerBit=3, reset in the middle of DATA with 3 bytes queued -> on the next edge tx=1, busy=0, count=0, empty=1; no further frames.
REQ-037 cyclesPerBit=0, write 0xFF -> a 10-clock frame: 0, then eight 1s, then 1; change cyclesPerBit to 7 mid-frame -> the current frame is unaffected.
